// File: rtl/mbox_req_responder.sv
// rtl/mbox_req_responder.sv - EBOX request responder: 16-word AC file plus parity-protected RAM backing store.
module mbox_req_responder #(
   parameter int MEMWORDS = 1024
) (
   input  logic         clk,
   input  logic         resetN,
   input  logic         eboxReq,
   input  logic         eboxRead,
   input  logic         eboxWrite,
   input  logic         eboxPSE,
   input  logic [13:35] eboxVMA,
   input  logic         vmaACRef,
   input  logic [0:35]  cacheDataWrite,
   input  logic         diagParFlip,
   output logic [0:35]  cacheDataRead,
   output logic         mboxRespIn,
   output logic         cshEBOXT0,
   output logic         mboxBusy,
   output logic         nxmErr,
   output logic         mbParErr
);

   localparam int AW = (MEMWORDS > 1) ? $clog2(MEMWORDS) : 1;
   localparam logic [10:0] MEM_LIMIT = 11'(MEMWORDS);

   typedef enum logic [2:0] {IDLE, RDWAIT, RDRESP, WRDONE, PAUSE} state_t;

   state_t      state;
   logic [9:0]  hold_idx;
   logic        hold_ac;
   logic        hold_read;
   logic        hold_write;
   logic        hold_pse;
   logic        hold_nxm;

   logic [0:35] ac_file [0:15];
   logic [0:36] ram [0:MEMWORDS-1];
   logic [0:36] ram_q;

   logic        req_nxm;
   logic        idle_write;
   logic        pause_write;
   logic        wr_en;
   logic        wr_ac;
   logic        wr_nxm;
   logic [9:0]  wr_idx;
   logic        wr_par;

   // Out-of-range memory references never touch the RAM; AC references are always in range.
   assign req_nxm     = !vmaACRef &&
                        ((eboxVMA[13:25] != '0) || ({1'b0, eboxVMA[26:35]} >= MEM_LIMIT));
   assign idle_write  = (state == IDLE) && eboxReq && eboxWrite && !eboxRead;
   assign pause_write = (state == PAUSE) && eboxReq && eboxWrite;
   assign wr_en       = resetN && (idle_write || pause_write);
   assign wr_ac       = idle_write ? vmaACRef : hold_ac;
   assign wr_nxm      = idle_write ? req_nxm : hold_nxm;
   assign wr_idx      = idle_write ? eboxVMA[26:35] : hold_idx;
   assign wr_par      = (~^cacheDataWrite) ^ diagParFlip;

   // Storage has no reset so its contents survive resetN.
   always_ff @(posedge clk) begin
      if (wr_en && !wr_nxm) begin
         if (wr_ac) begin
            ac_file[wr_idx[3:0]] <= cacheDataWrite;
         end else begin
            ram[wr_idx[AW-1:0]] <= {cacheDataWrite, wr_par};
         end
      end
      if ((state == RDWAIT) && !hold_nxm) begin
         ram_q <= ram[hold_idx[AW-1:0]];
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state         <= IDLE;
         hold_idx      <= '0;
         hold_ac       <= 1'b0;
         hold_read     <= 1'b0;
         hold_write    <= 1'b0;
         hold_pse      <= 1'b0;
         hold_nxm      <= 1'b0;
         cacheDataRead <= '0;
         mboxRespIn    <= 1'b0;
         cshEBOXT0     <= 1'b0;
         mboxBusy      <= 1'b0;
         nxmErr        <= 1'b0;
         mbParErr      <= 1'b0;
      end else begin
         cacheDataRead <= '0;
         mboxRespIn    <= 1'b0;
         cshEBOXT0     <= 1'b0;
         nxmErr        <= 1'b0;
         mbParErr      <= 1'b0;
         case (state)
            IDLE: begin
               if (eboxReq && (eboxRead || eboxWrite)) begin
                  hold_idx   <= eboxVMA[26:35];
                  hold_ac    <= vmaACRef;
                  hold_read  <= eboxRead;
                  hold_write <= eboxWrite && !eboxRead;
                  hold_pse   <= eboxPSE;
                  hold_nxm   <= req_nxm;
                  mboxBusy   <= 1'b1;
                  if (eboxRead) begin
                     if (vmaACRef) begin
                        state         <= RDRESP;
                        mboxRespIn    <= 1'b1;
                        cacheDataRead <= ac_file[eboxVMA[32:35]];
                     end else begin
                        state <= RDWAIT;
                     end
                  end else begin
                     state <= WRDONE;
                  end
               end
            end
            RDWAIT: begin
               state <= RDRESP;
            end
            RDRESP: begin
               // AC reads already responded on entry; RAM reads respond on the way out.
               if (hold_read && !hold_ac) begin
                  mboxRespIn    <= 1'b1;
                  nxmErr        <= hold_nxm;
                  cacheDataRead <= hold_nxm ? '0 : ram_q[0:35];
                  mbParErr      <= !hold_nxm && !(^ram_q);
               end
               state    <= hold_pse ? PAUSE : IDLE;
               mboxBusy <= hold_pse;
            end
            WRDONE: begin
               cshEBOXT0 <= hold_write;
               nxmErr    <= hold_write && hold_nxm;
               state     <= IDLE;
               mboxBusy  <= 1'b0;
            end
            PAUSE: begin
               if (eboxReq) begin
                  if (eboxWrite) begin
                     hold_read  <= 1'b0;
                     hold_write <= 1'b1;
                     hold_pse   <= 1'b0;
                     state      <= WRDONE;
                  end else begin
                     state    <= IDLE;
                     mboxBusy <= 1'b0;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               mboxBusy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mbox_req_responder.sv
// tb/tb_mbox_req_responder.sv - directed vector bench for mbox_req_responder.
module tb_mbox_req_responder;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        eboxReq = 1'b0;
   logic        eboxRead = 1'b0;
   logic        eboxWrite = 1'b0;
   logic        eboxPSE = 1'b0;
   logic        vmaACRef = 1'b0;
   logic        diagParFlip = 1'b0;
   logic [22:0] eboxVMA = '0;
   logic [35:0] cacheDataWrite = '0;
   logic [35:0] cacheDataRead;
   logic        mboxRespIn, cshEBOXT0, mboxBusy, nxmErr, mbParErr;

   int n_tests = 0;
   int n_fail  = 0;

   mbox_req_responder #(.MEMWORDS(1024)) dut (
      .clk(clk), .resetN(resetN), .eboxReq(eboxReq), .eboxRead(eboxRead),
      .eboxWrite(eboxWrite), .eboxPSE(eboxPSE), .eboxVMA(eboxVMA), .vmaACRef(vmaACRef),
      .cacheDataWrite(cacheDataWrite), .diagParFlip(diagParFlip), .cacheDataRead(cacheDataRead),
      .mboxRespIn(mboxRespIn), .cshEBOXT0(cshEBOXT0), .mboxBusy(mboxBusy),
      .nxmErr(nxmErr), .mbParErr(mbParErr)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drives one request at a negedge; req stays high until observation k == hold.
   // Bit k of each mask is the output seen at the k-th negedge after the sampling edge.
   task automatic issue(input bit rd, input bit wr, input bit pse, input bit ac, input bit flip,
                        input logic [22:0] vma, input logic [35:0] wd, input int hold, input int nobs,
                        output logic [15:0] resp_m, output logic [15:0] csh_m, output logic [15:0] nxm_m,
                        output logic [15:0] par_m, output logic [15:0] busy_m, output logic [35:0] rdata);
      resp_m = '0; csh_m = '0; nxm_m = '0; par_m = '0; busy_m = '0; rdata = '0;
      @(negedge clk);
      eboxReq = 1'b1; eboxRead = rd; eboxWrite = wr; eboxPSE = pse; vmaACRef = ac;
      diagParFlip = flip; eboxVMA = vma; cacheDataWrite = wd;
      for (int k = 1; k <= nobs; k++) begin
         @(negedge clk);
         if (k == hold) begin
            eboxReq = 1'b0; eboxRead = 1'b0; eboxWrite = 1'b0; eboxPSE = 1'b0; diagParFlip = 1'b0;
         end
         resp_m[k] = mboxRespIn;
         csh_m[k]  = cshEBOXT0;
         nxm_m[k]  = nxmErr;
         par_m[k]  = mbParErr;
         busy_m[k] = mboxBusy;
         if (mboxRespIn) rdata = cacheDataRead;
      end
   endtask

   typedef struct {
      bit          rd, wr, ac, flip;
      logic [22:0] vma;
      logic [35:0] wdata;
      int          resp_k, csh_k;
      logic [35:0] data;
      bit          nxm, par;
      logic [15:0] busy;
   } vec_t;

   vec_t vecs [18];

   logic [15:0] rm, cm, nm, pm, bm, exp_r, exp_c;
   logic [35:0] rd_data;
   int          resp_cnt;

   initial begin
      //          rd   wr   ac   flip vma      wdata           resp csh data            nxm  par  busy
      vecs[0]  = '{1'b0,1'b1,1'b0,1'b0,23'o100, 36'h123456789, 0, 2, 36'h0,          1'b0,1'b0,16'h0002};
      vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,23'o100, 36'h0,         3, 0, 36'h123456789, 1'b0,1'b0,16'h0006};
      vecs[2]  = '{1'b0,1'b1,1'b1,1'b0,23'o5,   36'o777,       0, 2, 36'h0,          1'b0,1'b0,16'h0002};
      vecs[3]  = '{1'b1,1'b0,1'b1,1'b0,23'o5,   36'h0,         1, 0, 36'o777,        1'b0,1'b0,16'h0002};
      vecs[4]  = '{1'b0,1'b1,1'b0,1'b1,23'o200, 36'hFFFFFFFFF, 0, 2, 36'h0,          1'b0,1'b0,16'h0002};
      vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,23'o200, 36'h0,         3, 0, 36'hFFFFFFFFF, 1'b0,1'b1,16'h0006};
      vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,23'o2000,36'h0,         3, 0, 36'h0,          1'b1,1'b0,16'h0006};
      vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,23'o4100,36'h5,         0, 2, 36'h0,          1'b1,1'b0,16'h0002};
      vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,23'o100, 36'h0,         3, 0, 36'h123456789, 1'b0,1'b0,16'h0006};
      vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,23'o100, 36'h0,         0, 0, 36'h0,          1'b0,1'b0,16'h0000};
      vecs[10] = '{1'b1,1'b1,1'b1,1'b0,23'o5,   36'hABC,       1, 0, 36'o777,        1'b0,1'b0,16'h0002};
      vecs[11] = '{1'b1,1'b0,1'b1,1'b0,23'o5,   36'h0,         1, 0, 36'o777,        1'b0,1'b0,16'h0002};
      vecs[12] = '{1'b0,1'b1,1'b1,1'b1,23'o17,  36'h800000001, 0, 2, 36'h0,          1'b0,1'b0,16'h0002};
      vecs[13] = '{1'b1,1'b0,1'b1,1'b0,23'o17,  36'h0,         1, 0, 36'h800000001, 1'b0,1'b0,16'h0002};
      vecs[14] = '{1'b0,1'b1,1'b0,1'b0,23'o1777,36'h0,         0, 2, 36'h0,          1'b0,1'b0,16'h0002};
      vecs[15] = '{1'b1,1'b0,1'b0,1'b0,23'o1777,36'h0,         3, 0, 36'h0,          1'b0,1'b0,16'h0006};
      vecs[16] = '{1'b0,1'b1,1'b1,1'b0,23'o4006,36'h42,        0, 2, 36'h0,          1'b0,1'b0,16'h0002};
      vecs[17] = '{1'b1,1'b0,1'b1,1'b0,23'o6,   36'h0,         1, 0, 36'h42,         1'b0,1'b0,16'h0002};

      repeat (2) @(negedge clk);
      check("reset_outputs", {28'h0, cacheDataRead, mboxRespIn, cshEBOXT0, mboxBusy, nxmErr, mbParErr}, 64'h0);
      resetN = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 18; i++) begin
         issue(vecs[i].rd, vecs[i].wr, 1'b0, vecs[i].ac, vecs[i].flip, vecs[i].vma, vecs[i].wdata,
               1, 5, rm, cm, nm, pm, bm, rd_data);
         exp_r = (vecs[i].resp_k != 0) ? 16'(1 << vecs[i].resp_k) : 16'h0;
         exp_c = (vecs[i].csh_k != 0) ? 16'(1 << vecs[i].csh_k) : 16'h0;
         check($sformatf("v%0d_resp", i), 64'(rm), 64'(exp_r));
         check($sformatf("v%0d_csh", i), 64'(cm), 64'(exp_c));
         check($sformatf("v%0d_data", i), 64'(rd_data), 64'(vecs[i].data));
         check($sformatf("v%0d_nxm", i), 64'(nm), vecs[i].nxm ? 64'(exp_r | exp_c) : 64'h0);
         check($sformatf("v%0d_par", i), 64'(pm), vecs[i].par ? 64'(exp_r) : 64'h0);
         check($sformatf("v%0d_busy", i), 64'(bm), 64'(vecs[i].busy));
      end

      // Requests held through busy states are dropped, not queued.
      issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 23'o100, 36'h0, 4, 8, rm, cm, nm, pm, bm, rd_data);
      check("b2b_ram_resp", 64'(rm), 64'h0048);
      check("b2b_ram_busy", 64'(bm), 64'h0036);
      issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 23'o5, 36'h0, 3, 6, rm, cm, nm, pm, bm, rd_data);
      check("b2b_ac_resp", 64'(rm), 64'h000A);
      issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'o500, 36'h7, 3, 6, rm, cm, nm, pm, bm, rd_data);
      check("b2b_wr_csh", 64'(cm), 64'h0014);

      // PSE read of A, then paused write aimed at B lands on A.
      issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'o300, 36'h00000ABCD, 1, 3, rm, cm, nm, pm, bm, rd_data);
      issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'o301, 36'h000000555, 1, 3, rm, cm, nm, pm, bm, rd_data);
      issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 23'o300, 36'h0, 1, 5, rm, cm, nm, pm, bm, rd_data);
      check("pse_resp", 64'(rm), 64'h0008);
      check("pse_data", 64'(rd_data), 64'h00000ABCD);
      check("pse_busy", 64'(bm), 64'h003E);
      issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'o301, 36'h00000ABCE, 1, 3, rm, cm, nm, pm, bm, rd_data);
      check("pause_wr_csh", 64'(cm), 64'h0004);
      check("pause_wr_busy", 64'(bm), 64'h0002);
      issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 23'o300, 36'h0, 1, 4, rm, cm, nm, pm, bm, rd_data);
      check("pause_addr_a", 64'(rd_data), 64'h00000ABCE);
      issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 23'o301, 36'h0, 1, 4, rm, cm, nm, pm, bm, rd_data);
      check("pause_addr_b", 64'(rd_data), 64'h000000555);

      // Non-write request abandons the pause without touching storage.
      issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 23'o300, 36'h0, 1, 4, rm, cm, nm, pm, bm, rd_data);
      issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 23'o301, 36'h0, 1, 4, rm, cm, nm, pm, bm, rd_data);
      check("abandon_resp", 64'(rm), 64'h0);
      check("abandon_busy", 64'(bm), 64'h0);
      issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 23'o300, 36'h0, 1, 4, rm, cm, nm, pm, bm, rd_data);
      check("abandon_data", 64'(rd_data), 64'h00000ABCE);

      // Reset while in RDWAIT.
      @(negedge clk);
      eboxReq = 1'b1; eboxRead = 1'b1; vmaACRef = 1'b0; eboxVMA = 23'o100;
      @(negedge clk);
      eboxReq = 1'b0; eboxRead = 1'b0;
      resetN = 1'b0;
      #1;
      check("rst_rdwait_busy", 64'(mboxBusy), 64'h0);
      resp_cnt = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         resp_cnt += int'(mboxRespIn);
         if (k == 2) resetN = 1'b1;
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         resp_cnt += int'(mboxRespIn);
      end
      check("rst_rdwait_noresp", 64'(resp_cnt), 64'h0);
      issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 23'o100, 36'h0, 1, 4, rm, cm, nm, pm, bm, rd_data);
      check("post_rst_resp", 64'(rm), 64'h0008);
      check("post_rst_data", 64'(rd_data), 64'h123456789);

      // Write whose accept edge falls inside reset must not modify storage.
      @(negedge clk);
      eboxReq = 1'b1; eboxWrite = 1'b1; vmaACRef = 1'b0; eboxVMA = 23'o100; cacheDataWrite = 36'hDEAD;
      resetN = 1'b0;
      @(negedge clk);
      eboxReq = 1'b0; eboxWrite = 1'b0;
      check("rst_wr_csh", 64'(cshEBOXT0), 64'h0);
      resetN = 1'b1;
      issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 23'o100, 36'h0, 1, 4, rm, cm, nm, pm, bm, rd_data);
      check("rst_wr_data", 64'(rd_data), 64'h123456789);

      // Reset while paused.
      issue(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 23'o5, 36'h0, 1, 3, rm, cm, nm, pm, bm, rd_data);
      check("ac_pse_busy", 64'(bm), 64'h000E);
      resetN = 1'b0;
      #1;
      check("rst_pause_busy", 64'(mboxBusy), 64'h0);
      @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
      check("rst_pause_idle", 64'(mboxBusy), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
